// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD card SPI bus arbiter.
package sd_arb_pkg;

    localparam int CNT_W = 8;
    localparam int TMR_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_INT  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        GUARD = 2'd0,
        IDLE  = 2'd1,
        HOST  = 2'd2,
        INT   = 2'd3
    } state_e;

    // Card pins and MISO returns while nobody owns the bus
    localparam logic IDLE_SCLK = 1'b0;
    localparam logic IDLE_MOSI = 1'b1;
    localparam logic IDLE_CS_N = 1'b1;
    localparam logic IDLE_MISO = 1'b1;

    function automatic owner_e owner_of(input state_e st);
        case (st)
            HOST:    return OWN_HOST;
            INT:     return OWN_INT;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sd_sync2.sv
// Two-flop synchroniser for a single asynchronous level, with a
// configurable value loaded on reset.
module sd_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sd_bus_arbiter.sv
// Shares the SD card SPI pins between the FTDI host passthrough and an internal
// SPI master. Optional INT ownership timeout is enabled by defining ARB_TIMEOUT_EN.
module sd_bus_arbiter
    import sd_arb_pkg::*;
#(
    parameter int IDLE_CYCLES    = 16,
    parameter int GUARD_CYCLES   = 4,
    parameter int INT_MAX_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_sclk,
    input  logic       host_mosi,
    input  logic       host_cs_n,
    output logic       host_miso,
    input  logic       int_req,
    output logic       int_gnt,
    input  logic       int_sclk,
    input  logic       int_mosi,
    input  logic       int_cs_n,
    output logic       int_miso,
    output logic       sd_sclk,
    output logic       sd_mosi,
    output logic       sd_cs_n,
    input  logic       sd_miso,
    output logic [1:0] owner,
    output logic       collision,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             hcs_s;
    logic             hcs_prev_q;
    logic             hcs_fall;
    logic             collision_q, collision_d;
    logic             timeout_q, timeout_d;
    logic             revoke;
    owner_e           owner_cur;

    sd_sync2 #(.RESET_VAL(1'b1)) u_hcs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (host_cs_n),
        .q_o   (hcs_s)
    );

    assign hcs_fall = hcs_prev_q & ~hcs_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [TMR_W-1:0] INT_LIMIT = TMR_W'(INT_MAX_CYCLES);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Held at zero outside INT so it restarts from the grant edge; saturates
    always_comb begin
        tmr_d = tmr_q;
        if (state_q != INT) begin
            tmr_d = '0;
        end else if (tmr_q != '1) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign revoke = (state_q == INT) && (tmr_q >= INT_LIMIT) && !hcs_s;
`else
    assign revoke = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        collision_d = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            GUARD: begin
                if (guard_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 1'b1;
                end
            end
            IDLE: begin
                if (!hcs_s) begin
                    state_d    = HOST;
                    idle_cnt_d = '0;
                end else if (int_req) begin
                    state_d = INT;
                end
            end
            HOST: begin
                if (!hcs_s) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d     = GUARD;
                    guard_cnt_d = GUARD_LAST;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            INT: begin
                if (revoke) begin
                    state_d     = GUARD;
                    guard_cnt_d = GUARD_LAST;
                    timeout_d   = 1'b1;
                end else begin
                    collision_d = hcs_fall;
                    if (!int_req) begin
                        state_d     = GUARD;
                        guard_cnt_d = GUARD_LAST;
                    end
                end
            end
            default: begin
                state_d     = GUARD;
                guard_cnt_d = GUARD_LAST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= GUARD;
            guard_cnt_q <= GUARD_LAST;
            idle_cnt_q  <= '0;
            hcs_prev_q  <= 1'b1;
            collision_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            hcs_prev_q  <= hcs_s;
            collision_q <= collision_d;
            timeout_q   <= timeout_d;
        end
    end

    // Pin routing depends only on the registered state, never on live requests
    assign owner_cur = owner_of(state_q);

    always_comb begin
        sd_sclk   = IDLE_SCLK;
        sd_mosi   = IDLE_MOSI;
        sd_cs_n   = IDLE_CS_N;
        host_miso = IDLE_MISO;
        int_miso  = IDLE_MISO;
        case (owner_cur)
            OWN_HOST: begin
                sd_sclk   = host_sclk;
                sd_mosi   = host_mosi;
                sd_cs_n   = host_cs_n;
                host_miso = sd_miso;
            end
            OWN_INT: begin
                sd_sclk  = int_sclk;
                sd_mosi  = int_mosi;
                sd_cs_n  = int_cs_n;
                int_miso = sd_miso;
            end
            default: begin
                sd_sclk = IDLE_SCLK;
            end
        endcase
    end

    assign owner     = owner_cur;
    assign int_gnt   = (state_q == INT);
    assign collision = collision_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Self-checking bench for sd_bus_arbiter: per-cycle expected snapshots are
// queued when stimulus is applied and popped as the DUT is sampled.
module tb_sd_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_sclk = 1'b0;
    logic       host_mosi = 1'b1;
    logic       host_cs_n = 1'b1;
    logic       host_miso;
    logic       int_req = 1'b0;
    logic       int_gnt;
    logic       int_sclk = 1'b0;
    logic       int_mosi = 1'b1;
    logic       int_cs_n = 1'b1;
    logic       int_miso;
    logic       sd_sclk;
    logic       sd_mosi;
    logic       sd_cs_n;
    logic       sd_miso = 1'b1;
    logic [1:0] owner;
    logic       collision;
    logic       timeout;

    int checks = 0;
    int passed = 0;

    // owner, int_gnt, sd_cs_n, collision, timeout
    typedef struct packed {
        logic [1:0] own;
        logic       gnt;
        logic       cs;
        logic       col;
        logic       to;
    } snap_t;

    snap_t exp_q[$];

    sd_bus_arbiter #(
        .IDLE_CYCLES    (16),
        .GUARD_CYCLES   (4),
        .INT_MAX_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_sclk (host_sclk),
        .host_mosi (host_mosi),
        .host_cs_n (host_cs_n),
        .host_miso (host_miso),
        .int_req   (int_req),
        .int_gnt   (int_gnt),
        .int_sclk  (int_sclk),
        .int_mosi  (int_mosi),
        .int_cs_n  (int_cs_n),
        .int_miso  (int_miso),
        .sd_sclk   (sd_sclk),
        .sd_mosi   (sd_mosi),
        .sd_cs_n   (sd_cs_n),
        .sd_miso   (sd_miso),
        .owner     (owner),
        .collision (collision),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic snap_t mk(logic [1:0] o, logic g, logic c, logic cl, logic t);
        return {o, g, c, cl, t};
    endfunction

    task automatic test_reset();
        snap_t a, e;
        rst_n = 1'b0; host_cs_n = 1'b1; int_req = 1'b0; int_cs_n = 1'b1;
        sd_miso = 1'b0; host_sclk = 1'b1; host_mosi = 1'b0; int_sclk = 1'b1; int_mosi = 1'b0;
        tick();
        checks++;
        if ({owner, int_gnt, sd_cs_n, sd_sclk, sd_mosi, host_miso, int_miso, collision, timeout}
                !== 10'b00_0_1_0_1_1_1_0_0)
            $display("FAIL reset_pins got %b want %b",
                {owner, int_gnt, sd_cs_n, sd_sclk, sd_mosi, host_miso, int_miso, collision, timeout},
                10'b00_0_1_0_1_1_1_0_0);
        else passed++;
        // request held from release: must wait out 4 guard cycles plus IDLE
        rst_n = 1'b1; int_req = 1'b1;
        repeat (4) exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd2, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 1; exp_q.size() > 0; i++) begin
            tick();
            e = exp_q.pop_front();
            a = {owner, int_gnt, sd_cs_n, collision, timeout};
            checks++;
            if (a !== e) $display("FAIL reset_seq cyc %0d got own/gnt/cs/col/to=%b want %b", i, a, e);
            else passed++;
            if (i == 5) int_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        snap_t a, e;
        logic [3:0] pa, pe;
        rst_n = 1'b0; host_cs_n = 1'b0; int_req = 1'b1; int_cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (4) exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (3) exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 1; exp_q.size() > 0; i++) begin
            tick();
            e = exp_q.pop_front();
            a = {owner, int_gnt, sd_cs_n, collision, timeout};
            checks++;
            if (a !== e) $display("FAIL simultaneous cyc %0d got own/gnt/cs/col/to=%b want %b", i, a, e);
            else passed++;
        end
        for (int k = 0; k < 4; k++) begin
            host_sclk = k[0];
            int_sclk  = ~k[0];
            host_mosi = 1'($urandom_range(1, 0));
            int_mosi  = ~host_mosi;
            sd_miso   = 1'($urandom_range(1, 0));
            #1;
            pa = {sd_sclk, sd_mosi, host_miso, int_miso};
            pe = {host_sclk, host_mosi, sd_miso, 1'b1};
            checks++;
            if (pa !== pe) $display("FAIL host_pins step %0d got sclk/mosi/hmiso/imiso=%b want %b", k, pa, pe);
            else passed++;
        end
    endtask

    task automatic test_host_release();
        snap_t a, e;
        host_cs_n = 1'b1;
        for (int i = 1; i <= 28; i++) exp_q.push_back(mk(2'd1, 1'b0, (i == 11) ? 1'b0 : 1'b1, 1'b0, 1'b0));
        repeat (5) exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd2, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 1; exp_q.size() > 0; i++) begin
            tick();
            e = exp_q.pop_front();
            a = {owner, int_gnt, sd_cs_n, collision, timeout};
            checks++;
            if (a !== e) $display("FAIL host_release cyc %0d got own/gnt/cs/col/to=%b want %b", i, a, e);
            else passed++;
            if (i == 10) host_cs_n = 1'b0;
            if (i == 11) host_cs_n = 1'b1;
        end
    endtask

    task automatic test_int_release();
        snap_t a, e;
        int_cs_n = 1'b0; sd_miso = 1'b0;
        exp_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (5) exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd2, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 1; exp_q.size() > 0; i++) begin
            tick();
            e = exp_q.pop_front();
            a = {owner, int_gnt, sd_cs_n, collision, timeout};
            checks++;
            if (a !== e) $display("FAIL int_release cyc %0d got own/gnt/cs/col/to=%b want %b", i, a, e);
            else passed++;
            if (i == 1) begin
                checks++;
                if ({int_miso, host_miso} !== 2'b01)
                    $display("FAIL int_miso got imiso/hmiso=%b want 01", {int_miso, host_miso});
                else passed++;
                int_req = 1'b0;
            end
            if (i == 2) begin
                int_req = 1'b1;
                int_cs_n = 1'b1;
            end
        end
    endtask

    task automatic test_collision();
        snap_t a, e;
        host_cs_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) exp_q.push_back(mk(2'd2, 1'b1, 1'b1, (i == 3), 1'b0));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        repeat (4) exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        for (int i = 1; i <= 14; i++) exp_q.push_back(mk(2'd2, 1'b1, 1'b1, (i == 3), 1'b0));
`endif
        for (int i = 1; exp_q.size() > 0; i++) begin
            tick();
            e = exp_q.pop_front();
            a = {owner, int_gnt, sd_cs_n, collision, timeout};
            checks++;
            if (a !== e) $display("FAIL collision cyc %0d got own/gnt/cs/col/to=%b want %b", i, a, e);
            else passed++;
        end
        int_req = 1'b0;
        host_cs_n = 1'b1;
    endtask

    task automatic test_midreset();
        snap_t a, e;
        for (int pass = 0; pass < 2; pass++) begin
            rst_n = 1'b0; host_cs_n = 1'b0; int_req = 1'b0; host_sclk = 1'b1;
            tick();
            if (pass == 1) begin
                checks++;
                if ({owner, int_gnt, sd_cs_n, sd_sclk} !== 5'b00_0_1_0)
                    $display("FAIL midreset got own/gnt/cs/sclk=%b want 00010", {owner, int_gnt, sd_cs_n, sd_sclk});
                else passed++;
            end
            rst_n = 1'b1;
            repeat (4) exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            repeat (2) exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int i = 1; exp_q.size() > 0; i++) begin
                tick();
                e = exp_q.pop_front();
                a = {owner, int_gnt, sd_cs_n, collision, timeout};
                checks++;
                if (a !== e) $display("FAIL midreset_seq p%0d cyc %0d got own/gnt/cs/col/to=%b want %b", pass, i, a, e);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_host_release();
        test_int_release();
        test_collision();
        test_midreset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_bus_arbiter.md
Name: sd_bus_arbiter

Overview:
- Shares the SD card SPI-mode pins (SCLK, MOSI, CS_n, MISO) between two owners:
  - the FTDI host passthrough path;
  - an on-chip SPI master (internal requester).
- Sits between the FTDI BDBUS pins, the internal SPI engine and the SD card pads.
- Switches ownership only when the bus is idle, and inserts guard cycles with the card deselected between owners.
- Host path is combinational (pin-to-pin), selected by a registered owner; only host CS_n is synchronised for arbitration.

Parameters:
- IDLE_CYCLES, 16: consecutive synchronised host_cs_n-high cycles before the host is considered idle; legal range 1..255.
- GUARD_CYCLES, 4: cycles in GUARD with card deselected before re-arbitration; legal range 1..255.
- INT_MAX_CYCLES, 4096: INT ownership limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (12 MHz board oscillator)
- rst_n  in  1  synchronous active-low reset
- host_sclk  in  1  FTDI SPI clock
- host_mosi  in  1  FTDI SPI data out
- host_cs_n  in  1  FTDI chip select (asynchronous to clk)
- host_miso  out  1  card data back to FTDI
- int_req  in  1  internal master bus request
- int_gnt  out  1  grant to internal master
- int_sclk  in  1  internal SPI clock
- int_mosi  in  1  internal SPI data out
- int_cs_n  in  1  internal chip select
- int_miso  out  1  card data back to internal master
- sd_sclk  out  1  card SCLK
- sd_mosi  out  1  card MOSI
- sd_cs_n  out  1  card CS_n
- sd_miso  in  1  card MISO
- owner  out  2  0 = none, 1 = host, 2 = internal
- collision  out  1  one-cycle pulse: host CS_n fell while INT owned the bus
- timeout  out  1  one-cycle pulse: INT ownership revoked (ARB_TIMEOUT_EN only)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is synchronous, active-low.
  - Reset is effective at the clk edge, including mid-transfer.
- Reset values:
  - state = GUARD, guard counter = GUARD_CYCLES-1.
  - int_gnt = 0, owner = 0, collision = 0, timeout = 0.
  - Pins take their idle levels.
- Idle pin levels (owner none): sd_cs_n = 1, sd_sclk = 0, sd_mosi = 1, host_miso = 1, int_miso = 1.
- Host CS_n handling:
  - host_cs_n passes through a 2-flop synchroniser giving hcs_s, reset value 1.
  - Arbitration latency is therefore 2 cycles, plus 1 cycle for the state register.
- Output muxing:
  - Pin outputs are a combinational mux controlled by the registered owner only.
  - A non-owner always sees MISO = 1.
- State GUARD:
  - Owner none.
  - Counter decrements; at 0 go to IDLE.
- State IDLE:
  - If hcs_s == 0, go to HOST. Host has priority, including when int_req is asserted in the same cycle.
  - Else if int_req == 1, go to INT; int_gnt and owner = 2 assert on the same edge.
- State HOST:
  - Owner = 1.
  - Idle counter counts consecutive hcs_s == 1 cycles; any hcs_s == 0 clears it.
  - When the count reaches IDLE_CYCLES, go to GUARD.
  - int_req is ignored; int_gnt stays 0.
- State INT:
  - Owner = 2, int_gnt = 1.
  - When int_req is deasserted, go to GUARD; int_gnt drops on that edge.
  - If int_cs_n is still 0 at that point, sd_cs_n is forced to 1 regardless; the internal master must raise CS before dropping its request.
  - A falling edge of hcs_s while in INT pulses collision for 1 cycle. The host is not granted and its transfer is lost.
- Requests must be held: an int_req drop in IDLE or GUARD simply cancels it.
- Counters are 8-bit; the INT timer is 16-bit and saturates, with no wrap-around.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit INT ownership timer counts from grant.
  - If the timer is ≥ INT_MAX_CYCLES and hcs_s == 0, the arbiter revokes the grant: go to GUARD, int_gnt = 0, timeout pulses 1 cycle, and collision is not pulsed for that edge.
  - After GUARD, the host wins IDLE.
- When undefined:
  - No timer.
  - INT ownership is never revoked.
  - timeout is tied to 0.

Decomposition:
- Package sd_arb_pkg holds:
  - owner enum: OWN_NONE = 0, OWN_HOST = 1, OWN_INT = 2;
  - state enum: GUARD, IDLE, HOST, INT;
  - idle pin level constants;
  - counter width constants (8 and 16).
- Sub-module sd_sync2 is the generic 2-flop synchroniser with a reset value parameter; it is instantiated for host_cs_n.

Test Plan:
- Reset release: sd_cs_n = 1, owner = 0 for 4 cycles, then IDLE. int_req = 1 at cycle 5 → int_gnt = 1 and owner = 2 at cycle 6.
- Simultaneous request: host_cs_n = 0 and int_req = 1 together from IDLE → owner = 1 after 3 cycles, int_gnt stays 0. With host_sclk toggling, sd_sclk mirrors it and int_miso = 1.
- Host release: host_cs_n goes high → owner = 1 for 16 synchronised cycles, then 4 GUARD cycles, then a pending int_req is granted. A 1-cycle CS glitch low at count 10 restarts the count.
- INT release with CS still 0: int_req drops while int_cs_n = 0 → sd_cs_n = 1 the next cycle, 4 GUARD cycles follow.
- Collision: during INT, host_cs_n falls → collision is a single pulse 3 cycles later, owner stays 2. With ARB_TIMEOUT_EN and INT_MAX_CYCLES = 8, the grant is revoked with a timeout pulse after cycle 8 and the host is granted after GUARD.
- Mid-transfer reset: rst_n = 0 for 1 cycle during HOST → next cycle owner = 0, sd_cs_n = 1, int_gnt = 0.
